// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver (16x s_tick, LSB first, no parity)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx           serial line, asynchronous to clk, idle high
//   s_tick       one-clk-wide pulse at 16x the baud rate
//   rx_done_tick one-clk pulse: new word on dout
//   dout         received word, right-aligned; bits above DBIT-1 are 0
//   frame_err    stop-bit level was 0 for the word on dout
//   busy         high while the receiver is not idle
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       busy
);

  // Tick counter covers one 16-tick bit; widened only when the stop period
  // is longer than one bit (1.5 or 2 stop bits).
  localparam int SW = (SB_TICK > 16) ? 5 : 4;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_start = 2'd1,
    st_data  = 2'd2,
    st_stop  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] s_cnt, s_next;
  logic [2:0]    n_cnt, n_next;
  logic [7:0]    shreg, shreg_next;

  logic          rx_meta, rx_s;

  logic          done_next;
  logic [7:0]    dout_next;
  logic          ferr_next;
  logic          busy_next;

  // State register, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= st_idle;
      s_cnt        <= '0;
      n_cnt        <= '0;
      shreg        <= '0;
      rx_done_tick <= 1'b0;
      dout         <= '0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_meta      <= rx;
      rx_s         <= rx_meta;
      state        <= state_next;
      s_cnt        <= s_next;
      n_cnt        <= n_next;
      shreg        <= shreg_next;
      rx_done_tick <= done_next;
      dout         <= dout_next;
      frame_err    <= ferr_next;
      busy         <= busy_next;
    end
  end

  // Next-state logic. The idle->start move ignores s_tick, so a tick in that
  // same cycle is not counted toward the half-bit start check.
  always_comb begin
    state_next = state;
    s_next     = s_cnt;
    n_next     = n_cnt;
    shreg_next = shreg;
    case (state)
      st_idle: begin
        if (!rx_s) begin
          state_next = st_start;
          s_next     = '0;
        end
      end
      st_start: begin
        if (s_tick) begin
          if (rx_s) begin
            state_next = st_idle;          // line went back high: glitch
          end else if (s_cnt == SW'(7)) begin
            state_next = st_data;          // middle of start bit reached
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
      st_data: begin
        if (s_tick) begin
          if (s_cnt == SW'(15)) begin
            s_next     = '0;
            shreg_next = {rx_s, shreg[7:1]};
            if (n_cnt == 3'(DBIT - 1)) begin
              state_next = st_stop;
            end else begin
              n_next = n_cnt + 1'b1;
            end
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
      st_stop: begin
        if (s_tick) begin
          if (s_cnt == SW'(SB_TICK - 1)) begin
            state_next = st_idle;
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  // Output logic: word and stop level are captured as the stop period ends.
  // With DBIT < 8 the word sits in the upper DBIT bits of shreg.
  always_comb begin
    done_next = (state == st_stop) && s_tick && (s_cnt == SW'(SB_TICK - 1));
    dout_next = dout;
    ferr_next = frame_err;
    if (done_next) begin
      dout_next = shreg >> (8 - DBIT);
      ferr_next = ~rx_s;
    end
    busy_next = (state_next != st_idle);
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx (DBIT 8 and 7)
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] tcnt = 2'd0;

  logic       rx8 = 1'b1, rx7 = 1'b1;
  logic       done8, done7, ferr8, ferr7, busy8, busy7;
  logic [7:0] dout8, dout7;

  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;
  logic prev8 = 1'b0, prev7 = 1'b0;

  // expected words: {frame_err, dout}
  logic [8:0] exp8[$];
  logic [8:0] exp7[$];
  logic [7:0] last8 = 8'h00;

  uart_rx #(.DBIT(8), .SB_TICK(16)) u8 (
    .clk(clk), .reset(reset), .rx(rx8), .s_tick(s_tick),
    .rx_done_tick(done8), .dout(dout8), .frame_err(ferr8), .busy(busy8)
  );

  uart_rx #(.DBIT(7), .SB_TICK(16)) u7 (
    .clk(clk), .reset(reset), .rx(rx7), .s_tick(s_tick),
    .rx_done_tick(done7), .dout(dout7), .frame_err(ferr7), .busy(busy7)
  );

  always #5 clk = ~clk;

  // free-running tick: one clk high out of every 4
  always @(posedge clk) begin
    tcnt   <= tcnt + 2'd1;
    s_tick <= (tcnt == 2'd3);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      chk("d8_width", 32'(prev8), 32'd0);
      if (exp8.size() == 0) begin
        chk("d8_unexpected", 32'd1, 32'd0);
      end else begin
        chk("d8_dout", 32'(dout8), 32'(exp8[0][7:0]));
        chk("d8_ferr", 32'(ferr8), 32'(exp8[0][8]));
        void'(exp8.pop_front());
      end
      done_cnt8 <= done_cnt8 + 1;
    end
    prev8 <= done8;
  end

  always @(negedge clk) begin
    if (done7) begin
      chk("d7_width", 32'(prev7), 32'd0);
      if (exp7.size() == 0) begin
        chk("d7_unexpected", 32'd1, 32'd0);
      end else begin
        chk("d7_dout", 32'(dout7), 32'(exp7[0][7:0]));
        chk("d7_ferr", 32'(ferr7), 32'(exp7[0][8]));
        chk("d7_msb", 32'(dout7[7]), 32'd0);
        void'(exp7.pop_front());
      end
    end
    prev7 <= done7;
  end

  task automatic hold(input int ticks);
    repeat (ticks * 4) @(posedge clk);
  endtask

  task automatic set_line(input int inst, input logic v);
    #1;
    if (inst == 0) rx8 = v;
    else rx7 = v;
  endtask

  // One frame at 16 ticks per bit. A bad stop is held low across the
  // receiver's stop sample, then released 4 ticks before the bit ends.
  task automatic send_frame(input int inst, input logic [7:0] data, input logic bad_stop);
    int nbits;
    logic [7:0] mask;
    nbits = (inst == 0) ? 8 : 7;
    mask  = (inst == 0) ? 8'hFF : 8'h7F;
    if (inst == 0) begin
      exp8.push_back({bad_stop, data & mask});
      last8 = data;
    end else begin
      exp7.push_back({bad_stop, data & mask});
    end
    set_line(inst, 1'b0);
    hold(16);
    for (int i = 0; i < nbits; i++) begin
      set_line(inst, data[i]);
      hold(16);
    end
    if (bad_stop) begin
      set_line(inst, 1'b0);
      hold(12);
      set_line(inst, 1'b1);
      hold(4);
    end else begin
      set_line(inst, 1'b1);
      hold(16);
    end
  endtask

  initial begin
    int cnt_before;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_dout8", 32'(dout8), 32'd0);
    chk("rst_ferr8", 32'(ferr8), 32'd0);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_dout7", 32'(dout7), 32'd0);
    chk("rst_busy7", 32'(busy7), 32'd0);

    // single clean frame
    send_frame(0, 8'hA5, 1'b0);
    hold(20);
    @(negedge clk);
    chk("a5_busy", 32'(busy8), 32'd0);
    chk("a5_count", 32'(done_cnt8), 32'd1);

    // back-to-back frames, no idle gap
    send_frame(0, 8'h00, 1'b0);
    send_frame(0, 8'hFF, 1'b0);
    hold(20);
    @(negedge clk);
    chk("b2b_count", 32'(done_cnt8), 32'd3);

    // 4-tick glitch on the line
    set_line(0, 1'b0);
    hold(4);
    set_line(0, 1'b1);
    hold(30);
    @(negedge clk);
    chk("glitch_busy", 32'(busy8), 32'd0);
    chk("glitch_dout", 32'(dout8), 32'(last8));
    chk("glitch_count", 32'(done_cnt8), 32'd3);

    // framing error followed by a clean frame
    send_frame(0, 8'h3C, 1'b1);
    send_frame(0, 8'h55, 1'b0);
    hold(20);
    @(negedge clk);
    chk("ferr_count", 32'(done_cnt8), 32'd5);

    // reset during data bit 4 of 0xC3
    set_line(0, 1'b0);
    hold(16);
    for (int i = 0; i < 4; i++) begin
      set_line(0, (8'hC3 >> i) & 8'h01 ? 1'b1 : 1'b0);
      hold(16);
    end
    set_line(0, 1'b0);
    hold(8);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    set_line(0, 1'b1);
    hold(20);
    @(negedge clk);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_dout", 32'(dout8), 32'd0);
    chk("abort_count", 32'(done_cnt8), 32'd5);
    send_frame(0, 8'h81, 1'b0);
    hold(20);
    @(negedge clk);
    chk("post_abort_count", 32'(done_cnt8), 32'd6);

    // 7-bit word
    send_frame(1, 8'h5A, 1'b0);
    hold(20);
    @(negedge clk);
    chk("d7_5a_dout", 32'(dout7), 32'h5A);
    chk("d7_busy", 32'(busy7), 32'd0);

    // randomized frames on both widths, random stop quality and gaps
    for (int k = 0; k < 14; k++) begin
      int inst;
      logic [7:0] d;
      logic bad;
      inst = int'($urandom_range(0, 1));
      d    = 8'($urandom);
      bad  = ($urandom_range(0, 3) == 0);
      send_frame(inst, d, bad);
      hold(int'($urandom_range(0, 3)));
    end
    hold(30);
    @(negedge clk);
    chk("q8_empty", 32'(exp8.size()), 32'd0);
    chk("q7_empty", 32'(exp7.size()), 32'd0);
    chk("end_busy8", 32'(busy8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
